mult_par_pipe: RTL and testbench

MULT_PAR_PIPE -- requirements
Module: mult_par_pipe

---
 rtl/mult_par_pipe.sv | 136 +++++++++++++
 tb/tb_mult_par_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_par_pipe.sv
// Pipelined signed multiplier with operand parity checking and a show-ahead result FIFO.
// Define MULT_PAR_CHECK_EN to enable operand parity checking; otherwise the parity inputs are ignored.
module mult_par_pipe #(
  parameter int DATA_W      = 16,
  parameter int PIPE_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DATA_W-1:0]   arg_a,
  input  logic                       arg_a_parity,
  input  logic signed [DATA_W-1:0]   arg_b,
  input  logic                       arg_b_parity,
  input  logic                       req,
  output logic                       ack,
  output logic signed [2*DATA_W-1:0] result,
  output logic                       result_parity,
  output logic                       arg_parity_error,
  output logic                       result_rdy,
  input  logic                       result_ack
);
  localparam int PW = 2 * DATA_W;
  localparam int EW = PW + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  function automatic logic even_parity(input logic [PW-1:0] v);
    return ^v;
  endfunction

  logic                   capture;
  logic                   push;
  logic                   pop;
  logic                   par_err;
  logic [PW-1:0]          a_ext;
  logic [PW-1:0]          b_ext;
  logic [PW-1:0]          prod;
  logic [EW-1:0]          stage_in;
  logic [EW-1:0]          push_data;
  logic [EW-1:0]          head_next;
  logic [CW-1:0]          occ;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          visible;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          head_idx;
  logic [PIPE_STAGES-1:0] pv;
  logic [EW-1:0]          pd  [PIPE_STAGES];
  logic [EW-1:0]          mem [FIFO_DEPTH];

`ifdef MULT_PAR_CHECK_EN
  // Operand parity mismatch detection
  always_comb begin
    par_err = (arg_a_parity != even_parity({{DATA_W{1'b0}}, arg_a})) ||
              (arg_b_parity != even_parity({{DATA_W{1'b0}}, arg_b}));
  end
`else
  logic unused_parity;
  assign unused_parity = arg_a_parity ^ arg_b_parity;
  always_comb begin
    par_err = 1'b0;
  end
`endif

  // Capture decision and the pipeline entry {error, parity, product}
  always_comb begin
    capture = req && !ack && (occ < DEPTH_C);
    a_ext   = {{DATA_W{arg_a[DATA_W-1]}}, arg_a};
    b_ext   = {{DATA_W{arg_b[DATA_W-1]}}, arg_b};
    prod    = a_ext * b_ext;
    if (par_err) begin
      stage_in = {1'b1, 1'b0, {PW{1'b0}}};
    end else begin
      stage_in = {1'b0, even_parity(prod), prod};
    end
  end

  // An entry pushed on an edge becomes visible at the head one edge later
  always_comb begin
    push      = pv[PIPE_STAGES-1];
    push_data = pd[PIPE_STAGES-1];
    pop       = result_ack && result_rdy;
    visible   = cnt - CW'(pop);
    head_idx  = rd_ptr + AW'(pop);
    if (visible != {CW{1'b0}}) begin
      head_next = mem[head_idx];
    end else begin
      head_next = {EW{1'b0}};
    end
  end

  // Multiplier pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv <= {PIPE_STAGES{1'b0}};
      for (int i = 0; i < PIPE_STAGES; i++) pd[i] <= {EW{1'b0}};
    end else begin
      pv[0] <= capture;
      pd[0] <= stage_in;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  // Result FIFO, credit counter and registered head outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= {EW{1'b0}};
      wr_ptr           <= {AW{1'b0}};
      rd_ptr           <= {AW{1'b0}};
      cnt              <= {CW{1'b0}};
      occ              <= {CW{1'b0}};
      ack              <= 1'b0;
      result_rdy       <= 1'b0;
      result           <= {PW{1'b0}};
      result_parity    <= 1'b0;
      arg_parity_error <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1'b1);
      end
      rd_ptr           <= head_idx;
      cnt              <= cnt + CW'(push) - CW'(pop);
      occ              <= occ + CW'(capture) - CW'(pop);
      ack              <= capture;
      result_rdy       <= (visible != {CW{1'b0}});
      result           <= head_next[PW-1:0];
      result_parity    <= head_next[PW];
      arg_parity_error <= head_next[PW+1];
    end
  end
endmodule

// File: tb/tb_mult_par_pipe.sv
// Self-checking bench for mult_par_pipe: directed vector table, hand-written corner sequences
// and a randomized run scored against a transaction-level reference model.
module tb_mult_par_pipe;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] arg_a = '0;
  logic          arg_a_parity = 1'b0;
  logic [DW-1:0] arg_b = '0;
  logic          arg_b_parity = 1'b0;
  logic          req = 1'b0;
  logic          ack;
  logic [2*DW-1:0] result;
  logic          result_parity;
  logic          arg_parity_error;
  logic          result_rdy;
  logic          result_ack = 1'b0;

  mult_par_pipe #(.DATA_W(DW), .PIPE_STAGES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .arg_a(arg_a), .arg_a_parity(arg_a_parity),
    .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .req(req), .ack(ack),
    .result(result), .result_parity(result_parity),
    .arg_parity_error(arg_parity_error), .result_rdy(result_rdy),
    .result_ack(result_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]   a;
    logic            ap;
    logic [DW-1:0]   b;
    logic            bp;
    logic [2*DW-1:0] res;
    logic            par;
    logic            err;
  } vec_t;

  vec_t tbl[6];
  logic [33:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int acks = 0;
  int to_issue = 0;
  bit gap_mode = 1'b0;
  logic prev_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: {parity_error, result_parity, result}
  function automatic logic [33:0] model(input logic [DW-1:0] a, input logic ap,
                                        input logic [DW-1:0] b, input logic bp);
    longint p;
    logic [31:0] r;
    bit bad;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
`ifdef MULT_PAR_CHECK_EN
    bad = (int'(ap) != ($countones(a) % 2)) || (int'(bp) != ($countones(b) % 2));
`else
    bad = 1'b0;
`endif
    if (bad) return {1'b1, 1'b0, 32'd0};
    return {1'b0, ($countones(r) % 2) == 1, r};
  endfunction

  task automatic new_ops();
    logic [DW-1:0] corner[4];
    corner[0] = 16'h8000; corner[1] = 16'h7FFF; corner[2] = 16'h0000; corner[3] = 16'hFFFF;
    arg_a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : DW'($urandom);
    arg_b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : DW'($urandom);
    arg_a_parity = ^arg_a ^ ($urandom_range(0, 7) == 0);
    arg_b_parity = ^arg_b ^ ($urandom_range(0, 7) == 0);
  endtask

  // One cycle of source/consumer activity, observed and driven at the falling edge
  task automatic tick(input bit pop_en);
    @(negedge clk);
    if (ack) begin
      check("ack_pulse", prev_ack, 1'b0);
      exp_q.push_back(model(arg_a, arg_a_parity, arg_b, arg_b_parity));
      check("credit", exp_q.size() <= 4, 1'b1);
      acks++;
      if (!gap_mode && to_issue > 0) begin
        new_ops(); to_issue--;
      end else begin
        req = 1'b0;
      end
    end else if (!req && to_issue > 0 && (!gap_mode || $urandom_range(0, 1) == 1)) begin
      new_ops(); req = 1'b1; to_issue--;
    end
    if (result_rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_rdy", result_rdy, 1'b0);
      end else begin
        check("head", {arg_parity_error, result_parity, result}, exp_q[0]);
        if (pop_en) void'(exp_q.pop_front());
      end
    end
    result_ack = pop_en;
    prev_ack = ack;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0; result_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; prev_ack = 1'b0; acks = 0; to_issue = 0;
    exp_q.delete();
  endtask

  task automatic single(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    arg_a = v.a; arg_a_parity = v.ap; arg_b = v.b; arg_b_parity = v.bp; req = 1'b1;
    @(negedge clk);
    check({tag, "_ack"}, ack, 1'b1);
    req = 1'b0;
    lat = 0;
    while (!result_rdy && lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_ack_one_cycle"}, ack, 1'b0);
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_out"}, {arg_parity_error, result_parity, result}, {v.err, v.par, v.res});
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check({tag, "_empty_after_pop"}, {result_rdy, arg_parity_error, result_parity, result}, 35'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit stale;
    logic [33:0] e;

    tbl[0] = '{a:16'h0003, ap:1'b0, b:16'hFFFE, bp:1'b1, res:32'hFFFF_FFFA, par:1'b0, err:1'b0};
    tbl[2] = '{a:16'h8000, ap:1'b1, b:16'h8000, bp:1'b1, res:32'h4000_0000, par:1'b1, err:1'b0};
    tbl[3] = '{a:16'h8000, ap:1'b1, b:16'h7FFF, bp:1'b1, res:32'hC000_8000, par:1'b1, err:1'b0};
    tbl[4] = '{a:16'h0000, ap:1'b0, b:16'h1234, bp:1'b1, res:32'h0000_0000, par:1'b0, err:1'b0};
`ifdef MULT_PAR_CHECK_EN
    tbl[1] = '{a:16'h0005, ap:1'b1, b:16'h0007, bp:1'b1, res:32'd0, par:1'b0, err:1'b1};
    tbl[5] = '{a:16'h0002, ap:1'b1, b:16'h0003, bp:1'b1, res:32'd0, par:1'b0, err:1'b1};
`else
    tbl[1] = '{a:16'h0005, ap:1'b1, b:16'h0007, bp:1'b1, res:32'd35, par:1'b1, err:1'b0};
    tbl[5] = '{a:16'h0002, ap:1'b1, b:16'h0003, bp:1'b1, res:32'd6, par:1'b0, err:1'b0};
`endif

    repeat (2) @(negedge clk);
    check("reset_outputs", {ack, result_rdy, arg_parity_error, result_parity, result}, 36'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) single(tbl[i], $sformatf("vec%0d", i));

    // Back-pressure: four captures fill the credit, the fifth waits for one pop
    do_reset();
    gap_mode = 1'b0; to_issue = 6;
    repeat (20) tick(1'b0);
    check("bp_acks", acks, 4);
    check("bp_rdy", result_rdy, 1'b1);
    check("bp_req_stalled", req, 1'b1);
    tick(1'b1);
    tick(1'b0);
    check("bp_no_ack_on_pop_edge", ack, 1'b0);
    tick(1'b0);
    check("bp_fifth_ack", ack, 1'b1);
    for (n = 0; n < 80; n++) begin
      tick(1'b1);
      if (to_issue == 0 && !req && exp_q.size() == 0) break;
    end
    check("bp_all_acked", acks, 6);
    check("bp_drained", exp_q.size(), 0);

    // Reset with entries buffered and one in flight
    do_reset();
    gap_mode = 1'b0; to_issue = 4;
    for (n = 0; n < 40 && acks < 4; n++) tick(1'b0);
    check("rst_setup_acks", acks, 4);
    do_reset();
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (result_rdy || ack || result != 32'd0 || result_parity || arg_parity_error) stale = 1'b1;
    end
    check("rst_no_stale", stale, 1'b0);
    single(tbl[0], "after_rst");

    // Request already high while reset is released
    @(negedge clk);
    rst_n = 1'b0;
    arg_a = tbl[2].a; arg_a_parity = tbl[2].ap; arg_b = tbl[2].b; arg_b_parity = tbl[2].bp;
    req = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_holds_ack_low", ack, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_capture", ack, 1'b1);
    req = 1'b0;
    n = 0;
    while (!result_rdy && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("release_out", {result_rdy, arg_parity_error, result_parity, result},
          {1'b1, tbl[2].err, tbl[2].par, tbl[2].res});
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;

    // Randomized traffic against the reference model
    do_reset();
    gap_mode = 1'b1; to_issue = 60;
    for (n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 2) != 0);
      if (to_issue == 0 && !req && exp_q.size() == 0) break;
    end
    @(negedge clk);
    result_ack = 1'b0;
    check("rand_all_acked", acks, 60);
    check("rand_drained", exp_q.size(), 0);
    check("rand_final_empty", result_rdy, 1'b0);
    e = model(16'h8000, 1'b1, 16'h8000, 1'b1);
    check("model_sanity", e, {1'b0, 1'b1, 32'h4000_0000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
